// File: rtl/add_seq_nbit_if.sv
// -----------------------------------------------------------------------------
// add_seq_nbit_if
// Request/response bundle for the multi-cycle chunked adder.
//   start       : request, only taken while busy is low
//   sub         : 0 = a + b + inputCarry, 1 = a - b
//   a, b        : operands, captured together with start
//   inputCarry  : carry-in for add, ignored for sub
//   busy        : operation in progress
//   done        : one-cycle pulse, result outputs valid
//   sum         : result
//   outputCarry : carry out of the MSB (for sub: 1 = no borrow)
//   overflow    : two's-complement overflow
//   zero        : sum == 0
// master drives the request side, slave is the adder.
// -----------------------------------------------------------------------------
interface add_seq_nbit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             inputCarry;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             outputCarry;
   logic             overflow;
   logic             zero;

   modport master (
      output start, sub, a, b, inputCarry,
      input  busy, done, sum, outputCarry, overflow, zero
   );

   modport slave (
      input  start, sub, a, b, inputCarry,
      output busy, done, sum, outputCarry, overflow, zero
   );
endinterface

// File: rtl/add_seq_nbit.sv
// -----------------------------------------------------------------------------
// add_seq_nbit
// Multi-cycle ripple adder/subtractor: one CHUNK-bit adder is reused over
// N = WIDTH/CHUNK cycles, least-significant chunk first.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : add_seq_nbit_if.slave (start/sub/a/b/inputCarry in,
//         busy/done/sum/outputCarry/overflow/zero out)
// Results are valid while done is high and stay held until the next
// accepted start.
// -----------------------------------------------------------------------------
module add_seq_nbit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic          clk,
   input  logic          rst,
   add_seq_nbit_if.slave bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;       // already inverted for subtract
   logic [WIDTH-1:0]   sum_r;
   logic               carry_r;
   logic [CNT_W-1:0]   cnt;
   logic               busy_r;
   logic               done_r;
   logic               oc_r;
   logic               ov_r;
   logic               zero_r;

   logic [CHUNK-1:0]   a_c;
   logic [CHUNK-1:0]   b_c;
   logic [CHUNK:0]     add_c;
   logic [WIDTH-1:0]   sum_nxt;
   logic               last;
   int                 idx;

   // Chunk slice and add for the current counter position
   always_comb begin
      idx     = int'(cnt) * CHUNK;
      a_c     = a_r[idx +: CHUNK];
      b_c     = b_r[idx +: CHUNK];
      add_c   = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_r};
      sum_nxt = sum_r;
      sum_nxt[idx +: CHUNK] = add_c[CHUNK-1:0];
      last    = (cnt == CNT_W'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sum_r   <= '0;
         oc_r    <= 1'b0;
         ov_r    <= 1'b0;
         zero_r  <= 1'b1;
         cnt     <= '0;
         carry_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // subtract as a + ~b + 1
                  a_r     <= bus.a;
                  b_r     <= bus.b ^ {WIDTH{bus.sub}};
                  carry_r <= bus.sub | bus.inputCarry;
                  cnt     <= '0;
                  state   <= RUN;
                  busy_r  <= 1'b1;
               end else begin
                  state   <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               sum_r   <= sum_nxt;
               carry_r <= add_c[CHUNK];
               cnt     <= cnt + 1'b1;
               if (last) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  oc_r   <= add_c[CHUNK];
                  // carry into the MSB recovered as a ^ b ^ s at that bit
                  ov_r   <= add_c[CHUNK] ^ a_r[WIDTH-1] ^ b_r[WIDTH-1]
                            ^ sum_nxt[WIDTH-1];
                  zero_r <= (sum_nxt == '0);
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.sum         = sum_r;
   assign bus.outputCarry = oc_r;
   assign bus.overflow    = ov_r;
   assign bus.zero        = zero_r;

endmodule

// File: tb/tb_add_seq_nbit.sv
// -----------------------------------------------------------------------------
// tb_add_seq_nbit
// Drives a CHUNK=4 adder with directed cases, and four adders (CHUNK 4, 1, 8,
// 32) with shared random operations, comparing against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_add_seq_nbit;

   localparam int WIDTH = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   add_seq_nbit_if #(.WIDTH(WIDTH)) bus   ();
   add_seq_nbit_if #(.WIDTH(WIDTH)) bus1  ();
   add_seq_nbit_if #(.WIDTH(WIDTH)) bus8  ();
   add_seq_nbit_if #(.WIDTH(WIDTH)) bus32 ();

   add_seq_nbit #(.WIDTH(WIDTH), .CHUNK(4))  dut    (.clk(clk), .rst(rst), .bus(bus));
   add_seq_nbit #(.WIDTH(WIDTH), .CHUNK(1))  dut_c1 (.clk(clk), .rst(rst), .bus(bus1));
   add_seq_nbit #(.WIDTH(WIDTH), .CHUNK(8))  dut_c8 (.clk(clk), .rst(rst), .bus(bus8));
   add_seq_nbit #(.WIDTH(WIDTH), .CHUNK(32)) dut_c32(.clk(clk), .rst(rst), .bus(bus32));

   // the extra configurations see exactly the same requests
   assign bus1.start  = bus.start;  assign bus1.sub  = bus.sub;  assign bus1.a  = bus.a;
   assign bus1.b      = bus.b;      assign bus1.inputCarry  = bus.inputCarry;
   assign bus8.start  = bus.start;  assign bus8.sub  = bus.sub;  assign bus8.a  = bus.a;
   assign bus8.b      = bus.b;      assign bus8.inputCarry  = bus.inputCarry;
   assign bus32.start = bus.start;  assign bus32.sub = bus.sub;  assign bus32.a = bus.a;
   assign bus32.b     = bus.b;      assign bus32.inputCarry = bus.inputCarry;

   logic [3:0]       dn, oc, ov, zr;
   logic [WIDTH-1:0] sm [4];
   assign dn = {bus32.done, bus8.done, bus1.done, bus.done};
   assign oc = {bus32.outputCarry, bus8.outputCarry, bus1.outputCarry, bus.outputCarry};
   assign ov = {bus32.overflow, bus8.overflow, bus1.overflow, bus.overflow};
   assign zr = {bus32.zero, bus8.zero, bus1.zero, bus.zero};
   assign sm[0] = bus.sum;
   assign sm[1] = bus1.sum;
   assign sm[2] = bus8.sum;
   assign sm[3] = bus32.sum;

   int lat_tab [4] = '{8, 32, 4, 1};

   typedef struct {
      logic             s;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             ci;
      logic [WIDTH-1:0] xs;
      logic             xc;
      logic             xv;
   } op_t;

   op_t dir [4] = '{
      '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
      '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
      '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
      '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1}
   };

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {overflow, carry, sum} from plain unsigned / signed arithmetic
   function automatic logic [33:0] model(input logic s, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
      logic [32:0] u;
      longint      sr;
      logic        ovf;
      if (s) begin
         u[31:0] = a - b;
         u[32]   = (a >= b);
         sr      = longint'($signed(a)) - longint'($signed(b));
      end else begin
         u  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
         sr = longint'($signed(a)) + longint'($signed(b)) + longint'({63'b0, ci});
      end
      ovf = (sr > SMAX) || (sr < SMIN);
      return {ovf, u};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int k, input logic s,
                            input logic [31:0] a, input logic [31:0] b, input logic ci);
      logic [33:0] m;
      m = model(s, a, b, ci);
      chk({tag, ".sum"},  64'(sm[k]), 64'(m[31:0]));
      chk({tag, ".cout"}, 64'(oc[k]), 64'(m[32]));
      chk({tag, ".ovf"},  64'(ov[k]), 64'(m[33]));
      chk({tag, ".zero"}, 64'(zr[k]), 64'(m[31:0] == 32'h0));
   endtask

   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic ci);
      bus.sub = s;  bus.a = a;  bus.b = b;  bus.inputCarry = ci;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // edges after the start edge until done, and busy cycles seen meanwhile
   task automatic wait_done(output int cyc, output int busy_cyc);
      cyc = 0;
      busy_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) break;
         if (bus.busy) busy_cyc++;
         tick();
         cyc++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   cyc, bcyc, c, nd, t;
      logic [3:0] seen;
      logic s, ci;
      logic [31:0] a, b, a2, b2;

      bus.start = 1'b0;  bus.sub = 1'b0;  bus.a = '0;  bus.b = '0;  bus.inputCarry = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst.busy", 64'(bus.busy), 64'(0));
      chk("rst.done", 64'(bus.done), 64'(0));
      chk("rst.sum",  64'(bus.sum),  64'(0));
      chk("rst.cout", 64'(bus.outputCarry), 64'(0));
      chk("rst.ovf",  64'(bus.overflow), 64'(0));
      chk("rst.zero", 64'(bus.zero), 64'(1));

      // start on the very first edge with rst low
      bus.a = 32'h0000_00FF;  bus.b = 32'h0000_0001;  bus.sub = 1'b0;  bus.inputCarry = 1'b0;
      bus.start = 1'b1;
      rst = 1'b0;
      tick();
      bus.start = 1'b0;
      wait_done(cyc, bcyc);
      chk("basic.lat",  64'(cyc),  64'(8));
      chk("basic.busy", 64'(bcyc), 64'(8));
      chk("basic.sum",  64'(bus.sum), 64'(32'h0000_0100));
      check_out("basic", 0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      tick();
      chk("basic.done_clr", 64'(bus.done), 64'(0));
      chk("basic.hold",     64'(bus.sum),  64'(32'h0000_0100));

      // corner operands with known results
      for (int i = 0; i < 4; i++) begin
         start_op(dir[i].s, dir[i].a, dir[i].b, dir[i].ci);
         wait_done(cyc, bcyc);
         chk("dir.lat",  64'(cyc), 64'(8));
         chk("dir.sum",  64'(bus.sum), 64'(dir[i].xs));
         chk("dir.cout", 64'(bus.outputCarry), 64'(dir[i].xc));
         chk("dir.ovf",  64'(bus.overflow), 64'(dir[i].xv));
         chk("dir.zero", 64'(bus.zero), 64'(dir[i].xs == 32'h0));
         tick();
      end

      // start re-pulsed in RUN with changing operands, then start in DONE
      a = 32'h1234_5678;  b = 32'h1111_1111;
      start_op(1'b0, a, b, 1'b0);
      c = 1;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) break;
         bus.start = (c == 3 || c == 5);
         bus.a = $urandom;  bus.b = $urandom;  bus.sub = 1'($urandom);
         tick();
         c++;
      end
      bus.start = 1'b0;
      chk("ignore.lat", 64'(c - 1), 64'(8));
      check_out("ignore", 0, 1'b0, a, b, 1'b0);
      a2 = $urandom;  b2 = $urandom;
      start_op(1'b1, a2, b2, 1'b1);
      chk("b2b.busy", 64'(bus.busy), 64'(1));
      wait_done(cyc, bcyc);
      chk("b2b.spacing", 64'(cyc + 1), 64'(9));
      check_out("b2b", 0, 1'b1, a2, b2, 1'b1);
      tick();

      // reset in the middle of RUN
      start_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort.busy", 64'(bus.busy), 64'(0));
      chk("abort.done", 64'(bus.done), 64'(0));
      chk("abort.sum",  64'(bus.sum),  64'(0));
      chk("abort.zero", 64'(bus.zero), 64'(1));
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) nd++;
      end
      chk("abort.nodone", 64'(nd), 64'(0));
      start_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
      wait_done(cyc, bcyc);
      chk("abort.relat", 64'(cyc), 64'(8));
      check_out("abort.re", 0, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

      // random operations over all four chunk sizes
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 300; n++) begin
         s = 1'($urandom);  ci = 1'($urandom);
         a = $urandom;      b = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h7FFF_FFFF;
            1: b = 32'h8000_0000;
            2: b = a;
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         start_op(s, a, b, ci);
         seen = 4'h0;
         t = 0;
         while (t <= 40) begin
            for (int k = 0; k < 4; k++) begin
               if (!seen[k] && dn[k]) begin
                  seen[k] = 1'b1;
                  chk("rnd.lat", 64'(t), 64'(lat_tab[k]));
                  check_out("rnd", k, s, a, b, ci);
               end
            end
            if (seen == 4'hF) break;
            tick();
            t++;
         end
         chk("rnd.alldone", 64'(seen), 64'(4'hF));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
